// File: rtl/lit_cell.sv
// lit_cell: one literal slot of a SAT clause row (polarity store, evaluation, free-count chain).
// Optional conflict-clause reporting is built only when LIT_CELL_CCLAUSE_EN is defined.
module lit_cell (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_i,
  input  logic [2:0] var_value_frombase_i,
  output logic [2:0] var_value_tobase_o,
  input  logic [1:0] freelitcnt_pre,
  output logic [1:0] freelitcnt_next,
  input  logic       imp_drv_i,
  output logic       cclause_o,
  input  logic       cclause_drv_i,
  output logic       clausesat_o
);

  logic [1:0] lit_r;
  logic [1:0] v_s;
  logic       present_s;
  logic       free_s;
  logic       true_s;
  logic       unused_s;

  assign v_s = var_value_frombase_i[2:1];

  // The implied flag is never consulted here; cclause_drv_i is idle when reporting is compiled out.
  assign unused_s = ^{var_value_frombase_i[0], cclause_drv_i};

  // Literal polarity register: loaded straight from the base value bus on a write strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lit_r <= 2'b00;
    end else if (wr_i) begin
      lit_r <= v_s;
    end else begin
      lit_r <= lit_r;
    end
  end

  // Literal evaluation against the broadcast value; encoding 11 behaves as an empty slot.
  always_comb begin
    present_s = 1'b0;
    case (lit_r)
      2'b01:   present_s = 1'b1;
      2'b10:   present_s = 1'b1;
      default: present_s = 1'b0;
    endcase
    free_s = present_s & (v_s == 2'b00);
    true_s = present_s & (v_s == lit_r);
  end

  // Free-count chain, implication and satisfaction outputs.
  always_comb begin
    freelitcnt_next    = freelitcnt_pre;
    var_value_tobase_o = 3'b000;
    if (free_s) begin
      freelitcnt_next = {freelitcnt_pre[0], 1'b1};
    end else begin
      freelitcnt_next = freelitcnt_pre;
    end
    if (imp_drv_i && free_s) begin
      var_value_tobase_o = {lit_r, 1'b1};
    end else begin
      var_value_tobase_o = 3'b000;
    end
    clausesat_o = true_s;
  end

`ifdef LIT_CELL_CCLAUSE_EN
  assign cclause_o = cclause_drv_i & present_s;
`else
  assign cclause_o = 1'b0;
`endif

endmodule

// File: tb/tb_lit_cell.sv
// Directed self-checking bench for lit_cell; expected values are hand-derived.
module tb_lit_cell;

  logic       clk;
  logic       rst;
  logic       wr_i;
  logic [2:0] var_value_frombase_i;
  logic [2:0] var_value_tobase_o;
  logic [1:0] freelitcnt_pre;
  logic [1:0] freelitcnt_next;
  logic       imp_drv_i;
  logic       cclause_o;
  logic       cclause_drv_i;
  logic       clausesat_o;

  int n_assert;
  int n_fail;

  lit_cell dut (
    .clk                  (clk),
    .rst                  (rst),
    .wr_i                 (wr_i),
    .var_value_frombase_i (var_value_frombase_i),
    .var_value_tobase_o   (var_value_tobase_o),
    .freelitcnt_pre       (freelitcnt_pre),
    .freelitcnt_next      (freelitcnt_next),
    .imp_drv_i            (imp_drv_i),
    .cclause_o            (cclause_o),
    .cclause_drv_i        (cclause_drv_i),
    .clausesat_o          (clausesat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef LIT_CELL_CCLAUSE_EN
  localparam logic CC_EN = 1'b1;
`else
  localparam logic CC_EN = 1'b0;
`endif

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] fb, input logic [1:0] pre, input logic imp, input logic cdrv);
    var_value_frombase_i = fb;
    freelitcnt_pre       = pre;
    imp_drv_i            = imp;
    cclause_drv_i        = cdrv;
    #1;
  endtask

  task automatic write_lit(input logic [1:0] lit);
    @(negedge clk);
    wr_i                 = 1'b1;
    var_value_frombase_i = {lit, 1'b0};
    @(posedge clk);
    #1;
    wr_i = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b0;
    wr_i = 1'b0;
    var_value_frombase_i = 3'b000;
    freelitcnt_pre = 2'b00;
    imp_drv_i = 1'b0;
    cclause_drv_i = 1'b0;

    // Reset state: empty slot passes the count through and reports nothing.
    drive(3'b000, 2'b01, 1'b1, 1'b1);
    check("rst_next", {1'b0, freelitcnt_next}, 3'b001);
    check("rst_sat", {2'b00, clausesat_o}, 3'b000);
    check("rst_tobase", var_value_tobase_o, 3'b000);
    check("rst_cclause", {2'b00, cclause_o}, 3'b000);
    @(negedge clk);
    rst = 1'b1;

    // Same-cycle write: outputs still reflect the old (empty) literal.
    @(negedge clk);
    wr_i = 1'b1;
    drive(3'b100, 2'b00, 1'b0, 1'b0);
    check("wr_same_cycle_sat", {2'b00, clausesat_o}, 3'b000);
    @(posedge clk);
    #1;
    wr_i = 1'b0;
    check("pos_after_wr_sat", {2'b00, clausesat_o}, 3'b001);

    // Positive literal.
    drive(3'b000, 2'b00, 1'b0, 1'b0);
    check("pos_free_00", {1'b0, freelitcnt_next}, 3'b001);
    drive(3'b010, 2'b01, 1'b0, 1'b0);
    check("pos_false_next", {1'b0, freelitcnt_next}, 3'b001);
    check("pos_false_sat", {2'b00, clausesat_o}, 3'b000);
    drive(3'b000, 2'b01, 1'b0, 1'b0);
    check("pos_free_01", {1'b0, freelitcnt_next}, 3'b011);
    drive(3'b000, 2'b11, 1'b0, 1'b0);
    check("pos_free_11", {1'b0, freelitcnt_next}, 3'b011);
    drive(3'b000, 2'b00, 1'b1, 1'b0);
    check("pos_imp", var_value_tobase_o, 3'b101);
    drive(3'b100, 2'b01, 1'b0, 1'b1);
    check("pos_true_sat", {2'b00, clausesat_o}, 3'b001);
    check("pos_true_next", {1'b0, freelitcnt_next}, 3'b001);
    check("pos_cclause", {2'b00, cclause_o}, {2'b00, CC_EN});
    drive(3'b101, 2'b00, 1'b0, 1'b0);
    check("pos_implied_ignored", {2'b00, clausesat_o}, 3'b001);
    drive(3'b110, 2'b00, 1'b0, 1'b0);
    check("pos_conflict_sat", {2'b00, clausesat_o}, 3'b000);
    check("pos_conflict_next", {1'b0, freelitcnt_next}, 3'b000);

    // Negative literal.
    write_lit(2'b01);
    drive(3'b010, 2'b00, 1'b0, 1'b0);
    check("neg_true_sat", {2'b00, clausesat_o}, 3'b001);
    drive(3'b110, 2'b01, 1'b0, 1'b0);
    check("neg_conflict_sat", {2'b00, clausesat_o}, 3'b000);
    check("neg_conflict_next", {1'b0, freelitcnt_next}, 3'b001);
    drive(3'b000, 2'b00, 1'b1, 1'b0);
    check("neg_imp", var_value_tobase_o, 3'b011);
    drive(3'b000, 2'b00, 1'b0, 1'b0);
    check("neg_noimp", var_value_tobase_o, 3'b000);
    drive(3'b100, 2'b00, 1'b1, 1'b0);
    check("neg_false_imp", var_value_tobase_o, 3'b000);
    drive(3'b100, 2'b10, 1'b0, 1'b0);
    check("illegal_pre_pass", {1'b0, freelitcnt_next}, 3'b010);
    drive(3'b000, 2'b10, 1'b0, 1'b0);
    check("illegal_pre_free", {1'b0, freelitcnt_next}, 3'b001);
    drive(3'b000, 2'b00, 1'b0, 1'b1);
    check("neg_cclause", {2'b00, cclause_o}, {2'b00, CC_EN});

    // Encoding 11 behaves as absent.
    write_lit(2'b11);
    drive(3'b110, 2'b00, 1'b1, 1'b1);
    check("abs11_sat", {2'b00, clausesat_o}, 3'b000);
    drive(3'b000, 2'b01, 1'b1, 1'b1);
    check("abs11_next", {1'b0, freelitcnt_next}, 3'b001);
    check("abs11_tobase", var_value_tobase_o, 3'b000);
    check("abs11_cclause", {2'b00, cclause_o}, 3'b000);

    // Cleared slot.
    write_lit(2'b00);
    drive(3'b000, 2'b00, 1'b0, 1'b1);
    check("cleared_cclause", {2'b00, cclause_o}, 3'b000);

    // Asynchronous reset mid-cycle while positive and true.
    write_lit(2'b10);
    drive(3'b100, 2'b11, 1'b0, 1'b0);
    check("pre_async_sat", {2'b00, clausesat_o}, 3'b001);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_sat", {2'b00, clausesat_o}, 3'b000);
    check("async_next", {1'b0, freelitcnt_next}, 3'b011);

    // Writes during reset are ignored.
    wr_i = 1'b1;
    drive(3'b100, 2'b00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("wr_in_rst_sat", {2'b00, clausesat_o}, 3'b000);
    @(negedge clk);
    wr_i = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_release_sat", {2'b00, clausesat_o}, 3'b000);
    write_lit(2'b10);
    drive(3'b100, 2'b00, 1'b0, 1'b0);
    check("wr_after_rst_sat", {2'b00, clausesat_o}, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lit_cell.md
# lit_cell

One literal slot of a clause row in the SAT clause bin. It stores the literal's polarity, evaluates the literal against the variable value broadcast from the variable base, and chains the clause's free-literal count. It also reports clause satisfaction, drives unit implications back to the base, and flags membership in a conflict clause. Cells are daisy-chained along a clause row through `freelitcnt_pre`/`freelitcnt_next`.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous, active-low (0 = reset).
- `wr_i`  in  1  write strobe; loads the literal polarity from `var_value_frombase_i[2:1]`.
- `var_value_frombase_i`  in  3  `[2:1]` is the variable value from the base (00 free, 01 false, 10 true, 11 conflict); `[0]` is the variable's implied flag, reserved and ignored by this cell.
- `var_value_tobase_o`  out  3  implication to the base: `[2:1]` is the implied value, `[0]` is valid.
- `freelitcnt_pre`  in  2  free-literal count from the previous cell (thermometer code: 00 zero, 01 one, 11 two or more).
- `freelitcnt_next`  out  2  free-literal count passed to the next cell.
- `imp_drv_i`  in  1  the clause is unit; this cell may drive its implication.
- `cclause_o`  out  1  this literal belongs to the conflicting clause.
- `cclause_drv_i`  in  1  the clause is in conflict; report membership.
- `clausesat_o`  out  1  this literal is true, so the clause is satisfied.

## Operation
- State is one 2-bit register `lit_q`.
  - 00 absent, 01 negative literal (¬x), 10 positive literal (x), 11 treated as absent.
- Write: when `wr_i` = 1 at a rising edge, `lit_q <= var_value_frombase_i[2:1]`. `wr_i` takes priority over nothing else because there is no other state.
- `present` = `lit_q` is 01 or 10. Let `v` = `var_value_frombase_i[2:1]`.
- Literal state, all combinational:
  - free = `present` & `v` == 00.
  - true = `present` & `v` == `lit_q`.
  - false = `present` & `v` != 00 & `v` != `lit_q`. A conflict value (`v` = 11) is therefore false.
- Count chain: `freelitcnt_next` = free ? {`freelitcnt_pre[0]`, 1} : `freelitcnt_pre`.
  - Saturating examples: 00→01, 01→11, 11→11.
  - Input 10 is illegal; it passes through unchanged when not free and becomes 01 when free.
- `clausesat_o` = true.
- Implication: `var_value_tobase_o` = (`imp_drv_i` & free) ? {`lit_q`, 1} : 000. A positive literal implies 10; a negative literal implies 01.
- Conflict clause: `cclause_o` = `cclause_drv_i` & `present` (subject to Configuration).

## Timing
- All outputs are combinational from `lit_q` and the current inputs, with zero-cycle latency.
- A write is visible from the cycle after the `wr_i` edge.
- Reset (`rst` = 0), asynchronous, including mid-operation: `lit_q` = 00 immediately. Outputs then settle to:
  - `freelitcnt_next` = `freelitcnt_pre` (pass-through);
  - `var_value_tobase_o` = 000;
  - `cclause_o` = 0;
  - `clausesat_o` = 0.
- `wr_i` asserted during reset is ignored. Writes resume on the first rising edge after `rst` returns to 1.
- If `wr_i` is asserted in the same cycle that `v` is evaluated, outputs still use the old `lit_q` for that cycle.
- No handshake and no stall.

## Configuration
- Macro `LIT_CELL_CCLAUSE_EN`.
- Defined: `cclause_o` behaves as in Operation.
- Undefined: `cclause_o` is tied to 0, `cclause_drv_i` is ignored, and no conflict-clause logic is synthesized.

## Test plan
- Reset, then `freelitcnt_pre`=01 with `v`=00 → `freelitcnt_next`=01, `clausesat_o`=0, `var_value_tobase_o`=000.
- Write 10 (positive); `v`=00, pre=00 → next=01. Then `v`=01, pre=01 → next=01, `clausesat_o`=0. Then `v`=00, pre=01 → next=11. With pre=11 → next=11.
- Positive literal, `v`=10 → `clausesat_o`=1, next=pre. Negative literal (write 01), `v`=01 → `clausesat_o`=1. Negative literal, `v`=11 → `clausesat_o`=0, next=pre.
- Negative literal, `v`=00, `imp_drv_i`=1 → `var_value_tobase_o`=011. With `imp_drv_i`=0 → 000. With `v`=10 → 000.
- With the macro defined: `cclause_drv_i`=1 and a literal present → `cclause_o`=1; after writing 00 → `cclause_o`=0. With the macro undefined: `cclause_o`=0 always.
- Drop `rst` asynchronously while the literal is positive and `v`=10 → `clausesat_o` falls to 0 before the next edge, and next equals pre.
